// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline controller: control-word layout,
// instruction-type and branch codes, flag positions and the bubble word.
package pipeline_ctrl_pkg;

    localparam int CWORD_W = 23;

    localparam int CW_TYPE = 0;
    localparam int CW_FUN3 = 4;
    localparam int CW_FUN7 = 7;
    localparam int CW_RD   = 8;
    localparam int CW_RS1  = 13;
    localparam int CW_RS2  = 18;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    // addi x0,x0,0: rd=0 so a bubble never forwards or writes anything
    localparam logic [CWORD_W-1:0] NOP_CWORD = 23'd1;

    typedef enum logic [3:0] {
        IT_LOAD   = 4'd0,
        IT_IMM    = 4'd1,
        IT_STORE  = 4'd2,
        IT_REG    = 4'd3,
        IT_LUI    = 4'd4,
        IT_AUIPC  = 4'd5,
        IT_BRANCH = 4'd6,
        IT_JALR   = 4'd7,
        IT_JAL    = 4'd8
    } inst_type_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_fun3_e;

    function automatic logic uses_rs1(input logic [3:0] t);
        return (t == IT_LOAD) || (t == IT_IMM) || (t == IT_STORE) ||
               (t == IT_REG) || (t == IT_BRANCH) || (t == IT_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [3:0] t);
        return (t == IT_STORE) || (t == IT_REG) || (t == IT_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_branch_eval.sv
// Branch condition decoder: maps the EX-stage fun3 and ZCNV flags to taken.
module pipeline_ctrl_branch_eval
    import pipeline_ctrl_pkg::*;
(
    input  logic [2:0] fun3_i,
    input  logic [3:0] flags_i,
    output logic       taken_o
);

    logic lt;

    // C=1 means no borrow, so unsigned less-than is !C
    always_comb begin
        taken_o = 1'b0;
        lt      = flags_i[FLAG_N] ^ flags_i[FLAG_V];
        case (fun3_i)
            BR_EQ:   taken_o = flags_i[FLAG_Z];
            BR_NE:   taken_o = ~flags_i[FLAG_Z];
            BR_LT:   taken_o = lt;
            BR_GE:   taken_o = ~lt;
            BR_LTU:  taken_o = ~flags_i[FLAG_C];
            BR_GEU:  taken_o = flags_i[FLAG_C];
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller: owns the EX/MEM/WB stage registers,
// inserts load-use bubbles, resolves branches/jumps in EX and counts events.
module pipeline_ctrl #(
    parameter int CNT_W = 32,
    parameter logic [pipeline_ctrl_pkg::CWORD_W-1:0] NOP_CWORD = pipeline_ctrl_pkg::NOP_CWORD
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [pipeline_ctrl_pkg::CWORD_W-1:0] cword_dec_i,
    input  logic [31:0]                          imm_dec_i,
    input  logic [31:0]                          pc_id_i,
    input  logic                                 id_valid_i,
    input  logic [3:0]                           funit_flags_i,
    input  logic [31:0]                          rs1_ex_i,
    output logic [pipeline_ctrl_pkg::CWORD_W-1:0] cwordID,
    output logic [pipeline_ctrl_pkg::CWORD_W-1:0] cwordEX,
    output logic [pipeline_ctrl_pkg::CWORD_W-1:0] cwordMEM,
    output logic [pipeline_ctrl_pkg::CWORD_W-1:0] cwordWB,
    output logic [31:0]                          immEX,
    output logic [31:0]                          immMEM,
    output logic [31:0]                          pc_ex_o,
    output logic                                 stall_o,
    output logic                                 flush_o,
    output logic [31:0]                          redirect_pc_o,
    output logic [CNT_W-1:0]                     stall_cnt_o,
    output logic [CNT_W-1:0]                     flush_cnt_o,
    output logic [CNT_W-1:0]                     retire_cnt_o
);
    import pipeline_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CWORD_W-1:0] cword_ex_q, cword_ex_d;
    logic [CWORD_W-1:0] cword_mem_q, cword_mem_d;
    logic [CWORD_W-1:0] cword_wb_q, cword_wb_d;
    logic [31:0]        imm_ex_q, imm_ex_d;
    logic [31:0]        imm_mem_q, imm_mem_d;
    logic [31:0]        pc_ex_q, pc_ex_d;
    logic               valid_ex_q, valid_ex_d;
    logic               valid_mem_q, valid_mem_d;
    logic               valid_wb_q, valid_wb_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;

    logic [3:0]  type_ex;
    logic [3:0]  type_id;
    logic [4:0]  rd_ex;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        br_taken;
    logic        load_use;
    logic        take;
    logic [31:0] target;

    assign type_ex = cword_ex_q[CW_TYPE +: 4];
    assign rd_ex   = cword_ex_q[CW_RD +: 5];
    assign type_id = cword_dec_i[CW_TYPE +: 4];
    assign rs1_id  = cword_dec_i[CW_RS1 +: 5];
    assign rs2_id  = cword_dec_i[CW_RS2 +: 5];

    pipeline_ctrl_branch_eval u_branch_eval (
        .fun3_i  (cword_ex_q[CW_FUN3 +: 3]),
        .flags_i (funit_flags_i),
        .taken_o (br_taken)
    );

    always_comb begin
        load_use = valid_ex_q && (type_ex == IT_LOAD) && (rd_ex != 5'd0) && id_valid_i &&
                   (((rd_ex == rs1_id) && uses_rs1(type_id)) ||
                    ((rd_ex == rs2_id) && uses_rs2(type_id)));
        take     = valid_ex_q && ((type_ex == IT_JALR) || (type_ex == IT_JAL) ||
                                  ((type_ex == IT_BRANCH) && br_taken));
        if (type_ex == IT_JALR) begin
            target = (rs1_ex_i + imm_ex_q) & 32'hFFFF_FFFE;
        end else begin
            target = pc_ex_q + imm_ex_q;
        end
    end

    assign cwordID       = id_valid_i ? cword_dec_i : NOP_CWORD;
    assign flush_o       = take;
    assign stall_o       = load_use && !take;
    assign redirect_pc_o = take ? target : 32'd0;

    // A redirect discards the ID instruction; a load-use holds it upstream.
    // Either way EX gets a bubble while MEM and WB always advance.
    always_comb begin
        cword_ex_d  = cwordID;
        imm_ex_d    = imm_dec_i;
        pc_ex_d     = pc_id_i;
        valid_ex_d  = id_valid_i;
        if (take || load_use) begin
            cword_ex_d = NOP_CWORD;
            imm_ex_d   = 32'd0;
            pc_ex_d    = 32'd0;
            valid_ex_d = 1'b0;
        end
        cword_mem_d = cword_ex_q;
        imm_mem_d   = imm_ex_q;
        valid_mem_d = valid_ex_q;
        cword_wb_d  = cword_mem_q;
        valid_wb_d  = valid_mem_q;

        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
        if (valid_wb_q && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cword_ex_q   <= NOP_CWORD;
            cword_mem_q  <= NOP_CWORD;
            cword_wb_q   <= NOP_CWORD;
            imm_ex_q     <= 32'd0;
            imm_mem_q    <= 32'd0;
            pc_ex_q      <= 32'd0;
            valid_ex_q   <= 1'b0;
            valid_mem_q  <= 1'b0;
            valid_wb_q   <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cword_ex_q   <= cword_ex_d;
            cword_mem_q  <= cword_mem_d;
            cword_wb_q   <= cword_wb_d;
            imm_ex_q     <= imm_ex_d;
            imm_mem_q    <= imm_mem_d;
            pc_ex_q      <= pc_ex_d;
            valid_ex_q   <= valid_ex_d;
            valid_mem_q  <= valid_mem_d;
            valid_wb_q   <= valid_wb_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cwordEX      = cword_ex_q;
    assign cwordMEM     = cword_mem_q;
    assign cwordWB      = cword_wb_q;
    assign immEX        = imm_ex_q;
    assign immMEM       = imm_mem_q;
    assign pc_ex_o      = pc_ex_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: expected stage entries are queued as
// instructions are offered and compared as they reach EX, MEM and WB.
module tb_pipeline_ctrl;

    localparam int          CW  = 4;
    localparam int          SAT = 15;
    localparam logic [22:0] NOP = 23'd1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [22:0]   cword_dec_i = '0;
    logic [31:0]   imm_dec_i = '0;
    logic [31:0]   pc_id_i = '0;
    logic          id_valid_i = 1'b0;
    logic [3:0]    funit_flags_i = '0;
    logic [31:0]   rs1_ex_i = '0;
    logic [22:0]   cwordID, cwordEX, cwordMEM, cwordWB;
    logic [31:0]   immEX, immMEM, pc_ex_o, redirect_pc_o;
    logic          stall_o, flush_o;
    logic [CW-1:0] stall_cnt_o, flush_cnt_o, retire_cnt_o;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cword_dec_i   (cword_dec_i),
        .imm_dec_i     (imm_dec_i),
        .pc_id_i       (pc_id_i),
        .id_valid_i    (id_valid_i),
        .funit_flags_i (funit_flags_i),
        .rs1_ex_i      (rs1_ex_i),
        .cwordID       (cwordID),
        .cwordEX       (cwordEX),
        .cwordMEM      (cwordMEM),
        .cwordWB       (cwordWB),
        .immEX         (immEX),
        .immMEM        (immMEM),
        .pc_ex_o       (pc_ex_o),
        .stall_o       (stall_o),
        .flush_o       (flush_o),
        .redirect_pc_o (redirect_pc_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .retire_cnt_o  (retire_cnt_o)
    );

    typedef struct {
        logic [22:0] cw;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        valid;
    } stage_t;

    // Front entry is MEM, back entry is EX between clock edges
    stage_t sb[$];
    int     compared   = 0;
    int     mismatched = 0;
    int     mStall, mFlush, mRetire;
    logic   mWbValid;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int satInc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic logic [22:0] mk(input int t, input int f3, input int rd, input int r1, input int r2);
        logic [4:0] rdB, r1B, r2B;
        logic [2:0] f3B;
        logic [3:0] tB;
        rdB = rd[4:0];
        r1B = r1[4:0];
        r2B = r2[4:0];
        f3B = f3[2:0];
        tB  = t[3:0];
        return {r2B, r1B, rdB, 1'b0, f3B, tB};
    endfunction

    function automatic logic brTake(input logic [2:0] f3, input logic [3:0] fl);
        logic z, c, n, v;
        {z, c, n, v} = fl;
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n != v;
            3'b101:  return n == v;
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    task automatic resetModel();
        stage_t bubble;
        bubble = '{NOP, 32'd0, 32'd0, 1'b0};
        sb.delete();
        sb.push_back(bubble);
        sb.push_back(bubble);
        mStall   = 0;
        mFlush   = 0;
        mRetire  = 0;
        mWbValid = 1'b0;
    endtask

    // One clock of stimulus: ID contents plus the EX-side flags and rs1
    task automatic applyStimulus(input logic [22:0] cw, input logic [31:0] imm, input logic [31:0] pc,
                                 input logic v, input logic [3:0] fl, input logic [31:0] r1,
                                 output logic stalled);
        stage_t ex, nxt, wb;
        logic [3:0] et, idt;
        logic [4:0] rd;
        logic useA, useB, lu, tk;
        logic [31:0] tgt;
        cword_dec_i   = cw;
        imm_dec_i     = imm;
        pc_id_i       = pc;
        id_valid_i    = v;
        funit_flags_i = fl;
        rs1_ex_i      = r1;
        #1;
        ex   = sb[$];
        et   = ex.cw[3:0];
        rd   = ex.cw[12:8];
        idt  = cw[3:0];
        useA = (idt <= 4'd3) || (idt == 4'd6) || (idt == 4'd7);
        useB = (idt == 4'd2) || (idt == 4'd3) || (idt == 4'd6);
        lu   = ex.valid && (et == 4'd0) && (rd != 5'd0) && v &&
               (((rd == cw[17:13]) && useA) || ((rd == cw[22:18]) && useB));
        tk   = ex.valid && ((et == 4'd7) || (et == 4'd8) || ((et == 4'd6) && brTake(ex.cw[6:4], fl)));
        tgt  = (et == 4'd7) ? ((r1 + ex.imm) & 32'hFFFF_FFFE) : (ex.pc + ex.imm);
        checkOutput("cwordID", cwordID, v ? cw : NOP);
        checkOutput("stall_o", stall_o, lu && !tk);
        checkOutput("flush_o", flush_o, tk);
        checkOutput("redirect_pc_o", redirect_pc_o, tk ? tgt : 32'd0);
        if (tk || lu) nxt = '{NOP, 32'd0, 32'd0, 1'b0};
        else          nxt = '{v ? cw : NOP, imm, pc, v};
        sb.push_back(nxt);
        if (mWbValid) mRetire = satInc(mRetire);
        if (lu && !tk) mStall = satInc(mStall);
        if (tk) mFlush = satInc(mFlush);
        stalled = lu && !tk;
        @(posedge clk);
        #1;
        wb       = sb.pop_front();
        mWbValid = wb.valid;
        checkOutput("cwordWB", cwordWB, wb.cw);
        checkOutput("cwordMEM", cwordMEM, sb[0].cw);
        checkOutput("cwordEX", cwordEX, sb[1].cw);
        if (sb[0].valid) checkOutput("immMEM", immMEM, sb[0].imm);
        if (sb[1].valid) begin
            checkOutput("immEX", immEX, sb[1].imm);
            checkOutput("pc_ex_o", pc_ex_o, sb[1].pc);
        end
        checkOutput("stall_cnt", stall_cnt_o, mStall);
        checkOutput("flush_cnt", flush_cnt_o, mFlush);
        checkOutput("retire_cnt", retire_cnt_o, mRetire);
    endtask

    // Offers an instruction, re-presenting it while the controller stalls
    task automatic issue(input logic [22:0] cw, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [3:0] fl, input logic [31:0] r1);
        logic stalled;
        int   tries;
        tries = 0;
        stalled = 1'b1;
        while (stalled && tries < 4) begin
            applyStimulus(cw, imm, pc, 1'b1, fl, r1, stalled);
            tries++;
        end
        if (stalled) checkOutput("stall_bound", 32'd1, 32'd0);
    endtask

    task automatic idle(input int n, input logic [3:0] fl);
        logic stalled;
        for (int i = 0; i < n; i++) applyStimulus(NOP, 32'd0, 32'd0, 1'b0, fl, 32'd0, stalled);
    endtask

    int f3s[7] = '{0, 1, 4, 5, 6, 7, 2};

    initial begin
        logic [22:0] addi1, lw2, add3, lw0, add30, beq, bltu, jalr, jal;
        addi1 = mk(1, 0, 1, 0, 0);
        lw2   = mk(0, 2, 2, 0, 0);
        add3  = mk(3, 0, 3, 2, 1);
        lw0   = mk(0, 2, 0, 0, 0);
        add30 = mk(3, 0, 3, 0, 1);
        beq   = mk(6, 0, 0, 1, 2);
        bltu  = mk(6, 6, 0, 1, 2);
        jalr  = mk(7, 0, 1, 5, 0);
        jal   = mk(8, 0, 1, 0, 0);

        // Reset held with random inputs
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cword_dec_i   = 23'($urandom);
            imm_dec_i     = $urandom;
            pc_id_i       = $urandom;
            id_valid_i    = 1'($urandom);
            funit_flags_i = 4'($urandom);
            rs1_ex_i      = $urandom;
            @(negedge clk);
        end
        checkOutput("rst_cwordEX", cwordEX, NOP);
        checkOutput("rst_cwordMEM", cwordMEM, NOP);
        checkOutput("rst_cwordWB", cwordWB, NOP);
        checkOutput("rst_stall", stall_o, 1'b0);
        checkOutput("rst_flush", flush_o, 1'b0);
        checkOutput("rst_cnt", {stall_cnt_o, flush_cnt_o, retire_cnt_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        resetModel();

        issue(addi1, 32'd5, 32'd0, 4'h0, 32'd0);
        idle(2, 4'h0);
        checkOutput("addi_at_wb", cwordWB, addi1);
        idle(1, 4'h0);
        checkOutput("addi_retired", retire_cnt_o, 32'd1);

        // Load-use: one stall, dependent instruction re-presented
        issue(lw2, 32'd0, 32'h04, 4'h0, 32'd0);
        issue(add3, 32'd0, 32'h08, 4'h0, 32'd0);
        checkOutput("lu_stall_cnt", stall_cnt_o, 32'd1);
        issue(lw0, 32'd0, 32'h0C, 4'h0, 32'd0);
        issue(add30, 32'd0, 32'h10, 4'h0, 32'd0);
        checkOutput("x0_no_stall", stall_cnt_o, 32'd1);

        // Branches: beq taken / not taken, bltu with C=0
        issue(beq, 32'd16, 32'h40, 4'h0, 32'd0);
        issue(addi1, 32'd1, 32'h44, 4'h8, 32'd0);
        issue(beq, 32'd16, 32'h50, 4'h0, 32'd0);
        issue(addi1, 32'd1, 32'h54, 4'h0, 32'd0);
        issue(bltu, 32'd8, 32'h60, 4'h0, 32'd0);
        issue(addi1, 32'd1, 32'h64, 4'h0, 32'd0);
        for (int i = 0; i < 7; i++) begin
            issue(mk(6, f3s[i], 0, 1, 2), 32'h20, 32'h100 + 32'(i * 16), 4'h0, 32'd0);
            issue(addi1, 32'd2, 32'h104 + 32'(i * 16), 4'($urandom_range(0, 15)), 32'd0);
        end

        // Jumps: jalr clears bit 0, jal wraps around
        issue(jalr, 32'd4, 32'h80, 4'h0, 32'd0);
        issue(addi1, 32'd0, 32'h84, 4'h0, 32'h0000_1001);
        issue(jal, 32'hFFFF_FFF0, 32'h10, 4'h0, 32'd0);
        issue(addi1, 32'd0, 32'h14, 4'h0, 32'd0);

        // Counter saturation
        for (int i = 0; i < SAT + 1; i++) begin
            issue(lw2, 32'd0, 32'h200, 4'h0, 32'd0);
            issue(add3, 32'd0, 32'h204, 4'h0, 32'd0);
        end
        checkOutput("stall_sat", stall_cnt_o, SAT);
        for (int i = 0; i < SAT + 1; i++) begin
            issue(jal, 32'd8, 32'h300, 4'h0, 32'd0);
            idle(1, 4'h0);
        end
        checkOutput("flush_sat", flush_cnt_o, SAT);
        checkOutput("retire_sat", retire_cnt_o, SAT);

        // Asynchronous reset while a taken branch sits in EX
        issue(beq, 32'd16, 32'h400, 4'h0, 32'd0);
        cword_dec_i   = addi1;
        id_valid_i    = 1'b1;
        funit_flags_i = 4'h8;
        #1;
        checkOutput("pre_rst_flush", flush_o, 1'b1);
        rst = 1'b0;
        #1;
        checkOutput("async_cwordEX", cwordEX, NOP);
        checkOutput("async_flush", flush_o, 1'b0);
        checkOutput("async_cnt", {stall_cnt_o, flush_cnt_o, retire_cnt_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        resetModel();
        issue(addi1, 32'd7, 32'h0, 4'h0, 32'd0);
        idle(4, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
